// File: rtl/mat_mult_seq.sv
// mat_mult_seq
// Sequential signed fixed-point matrix multiplier: OUT = A x B, one
// multiply-accumulate per clock, row-major output order. Operands are
// snapshotted on an accepted start. Each result element is rounded
// (half toward +inf after a FRAC_BITS right shift) and saturated to
// N_BITS on write-back. Any clamp raises the sticky sat flag.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, sampled only while idle
//   mat_a      operand A [SIZE_A][SIZE_B], captured on accepted start
//   mat_b      operand B [SIZE_B][SIZE_C], captured on accepted start
//   busy       high while a run (including its done cycle) is in progress
//   done       one-cycle completion pulse
//   out_valid  mat_out holds a complete result
//   sat        at least one element of the current/last run saturated
//   mat_out    registered result [SIZE_A][SIZE_C]
module mat_mult_seq #(
  parameter int SIZE_A    = 8,
  parameter int SIZE_B    = 8,
  parameter int SIZE_C    = 8,
  parameter int N_BITS    = 22,
  parameter int FRAC_BITS = 0,
  parameter int ACC_BITS  = 2*N_BITS + $clog2(SIZE_B) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [N_BITS-1:0] mat_a   [SIZE_A][SIZE_B],
  input  logic signed [N_BITS-1:0] mat_b   [SIZE_B][SIZE_C],
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic                     sat,
  output logic signed [N_BITS-1:0] mat_out [SIZE_A][SIZE_C]
);

  localparam int IW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int KW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam int JW = (SIZE_C > 1) ? $clog2(SIZE_C) : 1;
  localparam int PW = 2*N_BITS;

  localparam logic [IW-1:0] ILAST = IW'(SIZE_A-1);
  localparam logic [KW-1:0] KLAST = KW'(SIZE_B-1);
  localparam logic [JW-1:0] JLAST = JW'(SIZE_C-1);

  // Rounding offset is zero when there is no fractional shift, so the
  // same expression serves as the identity in that case.
  localparam int HB = (FRAC_BITS > 0) ? FRAC_BITS-1 : 0;
  localparam logic signed [ACC_BITS-1:0] HALF =
    (FRAC_BITS > 0) ? (ACC_BITS'(1) <<< HB) : '0;
  localparam logic signed [ACC_BITS-1:0] MAXV = (ACC_BITS'(1) <<< (N_BITS-1)) - ACC_BITS'(1);
  localparam logic signed [ACC_BITS-1:0] MINV = -(ACC_BITS'(1) <<< (N_BITS-1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic signed [ACC_BITS-1:0] rnd(input logic signed [ACC_BITS-1:0] v);
    return (v + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic ovf(input logic signed [ACC_BITS-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [N_BITS-1:0] clamp(input logic signed [ACC_BITS-1:0] v);
    if (v > MAXV)      return MAXV[N_BITS-1:0];
    else if (v < MINV) return MINV[N_BITS-1:0];
    else               return v[N_BITS-1:0];
  endfunction

  state_t                      state;
  logic [IW-1:0]               i;
  logic [KW-1:0]               k;
  logic [JW-1:0]               j;
  logic signed [N_BITS-1:0]    a_p0 [SIZE_A][SIZE_B];
  logic signed [N_BITS-1:0]    b_p0 [SIZE_B][SIZE_C];
  logic signed [ACC_BITS-1:0]  acc_p1;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_BITS-1:0]  acc_next;
  logic signed [ACC_BITS-1:0]  res_full;

  // Stage 0: operand snapshot, written only on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0 <= mat_a;
      b_p0 <= mat_b;
    end
  end

  // Single-cycle MAC; the first term of each element starts from zero so
  // nothing carries over between elements or runs.
  always_comb begin
    prod     = PW'(a_p0[i][k]) * PW'(b_p0[k][j]);
    acc_next = ((k == '0) ? '0 : acc_p1) + ACC_BITS'(prod);
    res_full = rnd(acc_next);
  end

  // Stage 1: accumulator, counters, control and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc_p1    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      for (int r = 0; r < SIZE_A; r++)
        for (int c = 0; c < SIZE_C; c++)
          mat_out[r][c] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc_p1    <= '0;
          end
        end
        RUN: begin
          acc_p1 <= acc_next;
          if (k == KLAST) begin
            k          <= '0;
            mat_out[i][j] <= clamp(res_full);
            if (ovf(res_full)) sat <= 1'b1;
            if (j == JLAST) begin
              j <= '0;
              if (i == ILAST) begin
                i         <= '0;
                state     <= DONE;
                done      <= 1'b1;
                out_valid <= 1'b1;
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed testbench for mat_mult_seq: four instances (8x8x8, 2x2x2,
// 1x1x1 integer and 1x1x1 with FRAC_BITS=8) share one clock and reset.
module tb_mat_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start8, start2, start1, startf;
  logic busy8, done8, ov8, sat8;
  logic busy2, done2, ov2, sat2;
  logic busy1, done1, ov1, sat1;
  logic busyf, donef, ovf_o, satf;

  logic signed [21:0] a8 [8][8];
  logic signed [21:0] b8 [8][8];
  logic signed [21:0] o8 [8][8];
  logic signed [21:0] a2 [2][2];
  logic signed [21:0] b2 [2][2];
  logic signed [21:0] o2 [2][2];
  logic signed [21:0] a1 [1][1];
  logic signed [21:0] b1 [1][1];
  logic signed [21:0] o1 [1][1];
  logic signed [21:0] af [1][1];
  logic signed [21:0] bf [1][1];
  logic signed [21:0] of [1][1];

  int n_checks = 0;
  int n_fail   = 0;

  mat_mult_seq u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mat_a(a8), .mat_b(b8),
    .busy(busy8), .done(done8), .out_valid(ov8), .sat(sat8), .mat_out(o8));

  mat_mult_seq #(.SIZE_A(2), .SIZE_B(2), .SIZE_C(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mat_a(a2), .mat_b(b2),
    .busy(busy2), .done(done2), .out_valid(ov2), .sat(sat2), .mat_out(o2));

  mat_mult_seq #(.SIZE_A(1), .SIZE_B(1), .SIZE_C(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mat_a(a1), .mat_b(b1),
    .busy(busy1), .done(done1), .out_valid(ov1), .sat(sat1), .mat_out(o1));

  mat_mult_seq #(.SIZE_A(1), .SIZE_B(1), .SIZE_C(1), .FRAC_BITS(8)) uf (
    .clk(clk), .rst_n(rst_n), .start(startf), .mat_a(af), .mat_b(bf),
    .busy(busyf), .done(donef), .out_valid(ovf_o), .sat(satf), .mat_out(of));

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits from the current negedge (counted as cycle 1) until done is seen.
  task automatic wait_done(input int which, input int budget, output int cycles);
    logic d;
    bit   seen;
    seen   = 1'b0;
    cycles = 1;
    for (int c = 0; c < budget; c++) begin
      case (which)
        8:       d = done8;
        2:       d = done2;
        1:       d = done1;
        default: d = donef;
      endcase
      if (d) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    check_eq($sformatf("done_seen_u%0d", which), longint'(seen), 1);
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      8:       start8 = v;
      2:       start2 = v;
      1:       start1 = v;
      default: startf = v;
    endcase
  endtask

  task automatic run_unit(input int which, input int budget, output int cycles);
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    wait_done(which, budget, cycles);
  endtask

  task automatic check_u2(input string tag);
    check_eq({tag, "_00"}, longint'(o2[0][0]), 7);
    check_eq({tag, "_01"}, longint'(o2[0][1]), 10);
    check_eq({tag, "_10"}, longint'(o2[1][0]), 15);
    check_eq({tag, "_11"}, longint'(o2[1][1]), 22);
  endtask

  task automatic run_frac(input int a, input int b, input int exp);
    int cyc;
    af[0][0] = 22'(a);
    bf[0][0] = 22'(b);
    run_unit(9, 10, cyc);
    check_eq($sformatf("frac_%0dx%0d", a, b), longint'(of[0][0]), longint'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_n, done_n, done_at, dn;
    logic signed [21:0] v16, v17;
    logic b10, b11;
    logic [21:0] bits;

    rst_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0; start1 = 1'b0; startf = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a8[r][c] = (r == c) ? 22'sd1 : 22'sd0;
        b8[r][c] = 22'(r*8 + c);
      end
    a2[0][0] = 1; a2[0][1] = 2; a2[1][0] = 3; a2[1][1] = 4;
    b2 = a2;
    a1[0][0] = 0; b1[0][0] = 0; af[0][0] = 0; bf[0][0] = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", longint'(busy8), 0);
    check_eq("rst_done", longint'(done8), 0);
    check_eq("rst_out_valid", longint'(ov8), 0);
    check_eq("rst_sat", longint'(sat8), 0);
    check_eq("rst_out", longint'(o8[3][5]), 0);
    rst_n = 1'b1;

    // Identity x ramp
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; v16 = 0; v17 = 0;
    for (int c = 1; c <= 600; c++) begin
      if (c > 1) @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        done_at = c;
      end
      if (c == 16) v16 = o8[0][1];
      if (c == 17) v17 = o8[0][1];
    end
    check_eq("id_busy_cycles", longint'(busy_n), 513);
    check_eq("id_done_pulses", longint'(done_n), 1);
    check_eq("id_done_cycle", longint'(done_at), 513);
    check_eq("id_elem01_before", longint'(v16), 0);
    check_eq("id_elem01_after", longint'(v17), 1);
    check_eq("id_sat", longint'(sat8), 0);
    check_eq("id_out_valid", longint'(ov8), 1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check_eq($sformatf("id_o8[%0d][%0d]", r, c), longint'(o8[r][c]), longint'(r*8 + c));

    // Back-to-back runs on 2x2x2
    run_unit(2, 20, cyc);
    check_eq("b2b_latency1", longint'(cyc), 9);
    check_u2("b2b_run1");
    start2 = 1'b1;
    @(negedge clk);
    check_eq("b2b_idle_busy", longint'(busy2), 0);
    check_eq("b2b_idle_valid", longint'(ov2), 1);
    @(negedge clk);
    start2 = 1'b0;
    check_eq("b2b_run2_busy", longint'(busy2), 1);
    check_eq("b2b_run2_valid", longint'(ov2), 0);
    wait_done(2, 20, cyc);
    check_eq("b2b_latency2", longint'(cyc), 9);
    check_u2("b2b_run2");

    // Start held high, then operand change after capture
    @(negedge clk);
    start2 = 1'b1;
    dn = 0; b10 = 1'b0; b11 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 10 && done2) dn++;
      if (c == 10) b10 = busy2;
      if (c == 11) b11 = busy2;
    end
    start2 = 1'b0;
    a2[0][0] = 0; a2[0][1] = 0; a2[1][0] = 0; a2[1][1] = 0;
    check_eq("held_done_pulses", longint'(dn), 1);
    check_eq("held_idle_busy", longint'(b10), 0);
    check_eq("held_reaccept_busy", longint'(b11), 1);
    wait_done(2, 20, cyc);
    check_u2("captured");

    // Signed and saturation on 1x1x1
    a1[0][0] = -22'sd3; b1[0][0] = 22'sd5;
    run_unit(1, 10, cyc);
    check_eq("s1_latency", longint'(cyc), 2);
    check_eq("s1_neg15", longint'(o1[0][0]), -15);
    bits = o1[0][0];
    check_eq("s1_bits", longint'(bits), 64'h3FFFF1);
    check_eq("s1_sat_clear", longint'(sat1), 0);
    a1[0][0] = 22'sh200000; b1[0][0] = 22'sh200000;
    run_unit(1, 10, cyc);
    check_eq("s1_clamp", longint'(o1[0][0]), 2097151);
    check_eq("s1_sat_set", longint'(sat1), 1);
    a1[0][0] = 22'sd1; b1[0][0] = 22'sd1;
    run_unit(1, 10, cyc);
    check_eq("s1_one", longint'(o1[0][0]), 1);
    check_eq("s1_sat_recleared", longint'(sat1), 0);

    // Fractional rounding, FRAC_BITS=8
    run_frac(384, 512, 768);
    run_frac(1, 128, 1);
    run_frac(1, 127, 0);
    run_frac(-1, 128, 0);
    run_frac(-1, 129, -1);
    check_eq("frac_sat", longint'(satf), 0);

    // Asynchronous reset during a run, then a clean rerun
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a8[r][c] = (r == c) ? 22'sd2 : 22'sd0;
        b8[r][c] = 22'(r*8 + c - 32);
      end
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_prev_elem", longint'(o8[7][7]), 63);
    check_eq("pre_rst_valid", longint'(ov8), 0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", longint'(busy8), 0);
    check_eq("arst_done", longint'(done8), 0);
    check_eq("arst_out_valid", longint'(ov8), 0);
    check_eq("arst_sat", longint'(sat8), 0);
    check_eq("arst_o77", longint'(o8[7][7]), 0);
    check_eq("arst_o01", longint'(o8[0][1]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    dn = 0; busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done8) dn++;
      if (busy8) busy_n++;
    end
    check_eq("post_rst_no_done", longint'(dn), 0);
    check_eq("post_rst_idle", longint'(busy_n), 0);
    run_unit(8, 600, cyc);
    check_eq("rerun_latency", longint'(cyc), 513);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check_eq($sformatf("rerun_o8[%0d][%0d]", r, c), longint'(o8[r][c]),
                 longint'(2*(r*8 + c - 32)));
    check_eq("rerun_sat", longint'(sat8), 0);
    check_eq("rerun_valid", longint'(ov8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
